cordic_seq_ctrl: RTL and testbench
==================================

// Module: cordic_seq_ctrl
// PURPOSE
//  Sequencer for the iterative CORDIC core behind the Nios custom-instruction port. Registers
//  the IEEE-754 operand, drives the combinational unpacker, and steps the shared CORDIC
//  datapath one micro-rotation per cycle. Runs the packer wait, then returns a 1-cycle done.
//  Special operands (0, +/-1, |x|>1) bypass the datapath and return constant results.
// PARAMETERS
//  N_ITER        16            micro-rotations per operation (>=1)
//  ITER_W        5             width of dp_iter; must satisfy 2**ITER_W >= N_ITER
//  PACK_LAT      2             cycles from last iteration to valid dp_result (>=0)
//  RES_ZERO      32'h3f800000  result for operand +/-0
//  RES_ONE       32'h3f0a5140  result for operand +/-1
//  RES_INVALID   32'h7fc00000  result (qNaN) for |x|>1, Inf, NaN
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  clk_en     in   1       global enable; low = every register holds
//  start      in   1       request; sampled only in IDLE with clk_en=1
//  dataa      in   32      IEEE-754 single operand
//  unp_data   out  32      registered operand to unpacker (op_q)
//  unp_sign   in   1       unpacker sign
//  unp_result in   32      unpacker fixed-point magnitude
//  unp_special in  1       unpacker flag: operand is 0 or +/-1
//  dp_load    out  1       1-cycle pulse: datapath loads unp_sign/unp_result
//  dp_en      out  1       datapath performs micro-rotation dp_iter this cycle
//  dp_iter    out  ITER_W  current iteration index
//  dp_result  in   32      packed float from datapath/packer
//  busy       out  1       high in every state except IDLE
//  done       out  1       1-cycle pulse, result valid in same cycle
//  result     out  32      registered result; holds until next done
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; op_q, dp_iter, result, cnt = 0; dp_load, dp_en, busy,
//    done = 0. Reset mid-operation abandons it; no done is produced.
//  - All transitions and register updates gated by clk_en; with clk_en=0 outputs are frozen
//    (a high done stays high until the next enabled edge).
//  - FSM: IDLE -start-> UNPACK (op_q<=dataa). UNPACK: classify op_q (exp=op_q[30:23]):
//      unp_special & op_q[30:0]==0 -> result<=RES_ZERO -> DONE
//      unp_special (else)          -> result<=RES_ONE  -> DONE
//      exp>=8'h7f & !unp_special   -> result<=RES_INVALID -> DONE
//      otherwise dp_load=1, dp_iter<=0 -> ITER
//    ITER: dp_en=1; dp_iter increments; at dp_iter==N_ITER-1 -> PACK (PACK_LAT=0: -> CAPTURE).
//    PACK: cnt counts PACK_LAT-1..0, dp_en=0 -> CAPTURE. CAPTURE: result<=dp_result -> DONE.
//    DONE: done=1 one cycle -> IDLE. start outside IDLE ignored (no queueing).
//  - Latency in enabled cycles from start edge to done high: normal 3+N_ITER+PACK_LAT
//    (19+PACK_LAT at default -> 21); special/invalid 2.
//  - dp_iter stays at N_ITER-1 after ITER until next dp_load; never wraps past N_ITER-1.
//  - Sign symmetry of special results is the caller's contract; ctrl ignores unp_sign there.
//  - Moore outputs decoded from state register; no combinational path start->done.
// STRUCTURE
//  - cordic_pkg: state enum (IDLE,UNPACK,ITER,PACK,CAPTURE,DONE), RES_* defaults,
//    FP_EXP_ONE=8'h7f, clog2 helper for ITER_W.
//  - Unpacker instantiated outside; this block only registers op_q and classifies.
//  - Single module; iteration/pack counter is an inline counter, no sub-module.
// TESTING
//  1 dataa=32'h3f000000 (0.5), start 1 cycle -> dp_load at +1, dp_en 16 cycles with
//    dp_iter 0..15, done at +21, result == dp_result driven by bench model.
//  2 dataa=32'h00000000 -> done at +2, result=32'h3f800000, dp_en/dp_load never high.
//  3 dataa=32'hbf800000 -> done at +2, result=32'h3f0a5140; dataa=32'h40000000 -> 32'h7fc00000.
//  4 start held high continuously -> back-to-back ops, one done each, new op_q only in IDLE.
//  5 clk_en low 5 cycles mid-ITER -> dp_iter frozen, done delayed exactly 5 cycles.
//  6 rst_n low at dp_iter=7 -> all outputs 0 immediately; no done; next start runs cleanly.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC custom-instruction sequencer.
package cordic_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_UNPACK  = 3'd1;
    localparam logic [2:0] ST_ITER    = 3'd2;
    localparam logic [2:0] ST_PACK    = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [31:0] RES_ZERO_DEF    = 32'h3f800000;
    localparam logic [31:0] RES_ONE_DEF     = 32'h3f0a5140;
    localparam logic [31:0] RES_INVALID_DEF = 32'h7fc00000;

    localparam logic [7:0] FP_EXP_ONE = 8'h7f;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC core: operand capture, classification,
// micro-rotation stepping, packer wait and 1-cycle done.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int          N_ITER      = 16,
    parameter int          ITER_W      = 5,
    parameter int          PACK_LAT    = 2,
    parameter logic [31:0] RES_ZERO    = RES_ZERO_DEF,
    parameter logic [31:0] RES_ONE     = RES_ONE_DEF,
    parameter logic [31:0] RES_INVALID = RES_INVALID_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              start,
    input  logic [31:0]       dataa,
    output logic [31:0]       unp_data,
    input  logic              unp_sign,
    input  logic [31:0]       unp_result,
    input  logic              unp_special,
    output logic              dp_load,
    output logic              dp_en,
    output logic [ITER_W-1:0] dp_iter,
    input  logic [31:0]       dp_result,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);

    localparam int CNT_W = (PACK_LAT > 1) ? clog2(PACK_LAT) : 1;
    localparam logic [2:0] ST_AFTER_ITER =
        (PACK_LAT == 0) ? ST_CAPTURE : ST_PACK;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(PACK_LAT - 1);

    logic [2:0]       state;
    logic [31:0]      op_q;
    logic [CNT_W-1:0] cnt;

    logic       is_zero;
    logic       is_invalid;
    logic       is_normal;
    logic [7:0] exp_q;

    // Sign and magnitude go straight from the unpacker into the datapath.
    logic unused_unp;
    assign unused_unp = ^{unp_sign, unp_result};

    assign exp_q      = op_q[30:23];
    assign is_zero    = unp_special && (op_q[30:0] == 31'd0);
    assign is_invalid = !unp_special && (exp_q >= FP_EXP_ONE);
    assign is_normal  = !unp_special && !is_invalid;

    assign unp_data = op_q;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign dp_en    = (state == ST_ITER);
    assign dp_load  = (state == ST_UNPACK) && is_normal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            dp_iter <= '0;
            result  <= '0;
            cnt     <= '0;
        end else if (clk_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= dataa;
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (is_zero) begin
                        result <= RES_ZERO;
                        state  <= ST_DONE;
                    end else if (unp_special) begin
                        result <= RES_ONE;
                        state  <= ST_DONE;
                    end else if (is_invalid) begin
                        result <= RES_INVALID;
                        state  <= ST_DONE;
                    end else begin
                        dp_iter <= '0;
                        state   <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    // dp_iter parks on the last index until the next load
                    if (dp_iter == LAST_ITER) begin
                        cnt   <= CNT_INIT;
                        state <= ST_AFTER_ITER;
                    end else begin
                        dp_iter <= dp_iter + 1'b1;
                    end
                end
                ST_PACK: begin
                    if (cnt == '0) state <= ST_CAPTURE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    result <= dp_result;
                    state  <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl with a small unpacker/datapath model.
module tb_cordic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] unp_data;
    logic        unp_sign;
    logic [31:0] unp_result;
    logic        unp_special;
    logic        dp_load;
    logic        dp_en;
    logic [4:0]  dp_iter;
    logic [31:0] dp_result;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Unpacker: flags +/-0 and +/-1. Datapath result tags operand and index.
    assign unp_sign    = unp_data[31];
    assign unp_result  = {9'd0, unp_data[22:0]};
    assign unp_special = (unp_data[30:0] == 31'd0) ||
                         (unp_data[30:0] == 31'h3f800000);
    assign dp_result   = {unp_data[15:0], 11'd0, dp_iter};

    cordic_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .start       (start),
        .dataa       (dataa),
        .unp_data    (unp_data),
        .unp_sign    (unp_sign),
        .unp_result  (unp_result),
        .unp_special (unp_special),
        .dp_load     (dp_load),
        .dp_en       (dp_en),
        .dp_iter     (dp_iter),
        .dp_result   (dp_result),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        int          lat;
        int          nload;
        int          nen;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic run_op(input vec_t v, input string nm);
        int lat;
        int nload;
        int nen;
        int bad_iter;
        lat = 0; nload = 0; nen = 0; bad_iter = 0;
        dataa = v.a;
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) break;
            if (dp_load) nload++;
            if (dp_en) begin
                if (int'(dp_iter) != nen) bad_iter++;
                nen++;
            end
        end
        chk({nm, " latency"}, lat, v.lat);
        chk({nm, " result"}, result, v.res);
        chk({nm, " dp_load count"}, nload, v.nload);
        chk({nm, " dp_en count"}, nen, v.nen);
        chk({nm, " dp_iter order"}, bad_iter, 0);
        chk({nm, " busy at done"}, busy, 1);
        @(posedge clk);
        #1;
        chk({nm, " done pulse/idle"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [31:0] first_res;
        logic [31:0] second_res;

        vecs[0]  = '{32'h3f000000, 32'h0000000f, 21, 1, 16};
        vecs[1]  = '{32'h3f123456, 32'h3456000f, 21, 1, 16};
        vecs[2]  = '{32'h3e80abcd, 32'habcd000f, 21, 1, 16};
        vecs[3]  = '{32'h00000001, 32'h0001000f, 21, 1, 16};
        vecs[4]  = '{32'h00000000, 32'h3f800000, 2, 0, 0};
        vecs[5]  = '{32'h80000000, 32'h3f800000, 2, 0, 0};
        vecs[6]  = '{32'hbf800000, 32'h3f0a5140, 2, 0, 0};
        vecs[7]  = '{32'h3f800000, 32'h3f0a5140, 2, 0, 0};
        vecs[8]  = '{32'h40000000, 32'h7fc00000, 2, 0, 0};
        vecs[9]  = '{32'h7f800000, 32'h7fc00000, 2, 0, 0};
        vecs[10] = '{32'h3f800001, 32'h7fc00000, 2, 0, 0};

        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; dataa = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", {busy, done, dp_load, dp_en}, 4'b0000);
        chk("reset dp_iter", dp_iter, 0);
        chk("reset result", result, 0);
        chk("reset op", unp_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // start held high: back-to-back ops, op_q only taken in IDLE
        dataa = 32'h00000000;
        start = 1'b1;
        ndone = 0;
        first_res = '0;
        second_res = '0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) dataa = 32'hbf800000;
            if (e == 2) chk("held op_q kept", unp_data, 32'h0);
            if (done) begin
                ndone++;
                if (ndone == 1) first_res = result;
                if (ndone == 2) second_res = result;
            end
        end
        start = 1'b0;
        chk("held done count", ndone, 4);
        chk("held first result", first_res, 32'h3f800000);
        chk("held second result", second_res, 32'h3f0a5140);
        chk("held ends idle", busy, 0);

        // clk_en low for 5 cycles mid-ITER
        dataa = 32'h3f000000;
        start = 1'b1;
        lat = 0;
        repeat (7) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        chk("stall pre iter", dp_iter, 5);
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            lat++;
            chk("stall frozen iter", {dp_en, 27'd0, dp_iter}, {1'b1, 27'd0, 5'd5});
        end
        clk_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        chk("stall latency", lat, 26);
        chk("stall result", result, 32'h0000000f);
        @(posedge clk);
        #1;

        // reset mid-operation
        dataa = 32'h3f123456;
        start = 1'b1;
        repeat (9) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("abort at iter", dp_iter, 7);
        rst_n = 1'b0;
        #1;
        chk("abort ctrl", {busy, done, dp_load, dp_en}, 4'b0000);
        chk("abort dp_iter", dp_iter, 0);
        chk("abort result", result, 0);
        chk("abort op", unp_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort no done", ndone, 0);
        run_op(vecs[0], "post-abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
